// File: rtl/agu_respq_pkg.sv
// agu_resp_queue shared types: entry layout, access sizes, default widths.
package agu_respq_pkg;

  localparam int DEPTH_D  = 4;
  localparam int BR_W_D   = 20;
  localparam int ADDR_W_D = 40;
  localparam int DATA_W_D = 65;
  localparam int ROB_W_D  = 7;
  localparam int LSQ_W_D  = 5;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef struct packed {
    logic [ADDR_W_D-1:0] addr;
    logic [DATA_W_D-1:0] data;
    logic                mxcpt;
    logic                is_load;
    logic                is_sta;
    logic                is_std;
    logic [1:0]          mem_size;
    logic [ROB_W_D-1:0]  rob_idx;
    logic [LSQ_W_D-1:0]  ldq_idx;
    logic [LSQ_W_D-1:0]  stq_idx;
  } payload_t;

  typedef struct packed {
    logic              valid;
    logic [BR_W_D-1:0] br_mask;
    payload_t          pl;
  } entry_t;

endpackage

// File: rtl/agu_respq_brmask_upd.sv
// Per-entry branch update: kill on mispredict, drop resolved mask bits.
module agu_respq_brmask_upd #(
  parameter int BR_W = 20
) (
  input  logic            in_valid,
  input  logic [BR_W-1:0] in_mask,
  input  logic [BR_W-1:0] resolve_mask,
  input  logic [BR_W-1:0] mispredict_mask,
  output logic            out_valid,
  output logic [BR_W-1:0] out_mask
);

  assign out_valid = in_valid & ~|(in_mask & mispredict_mask);
  assign out_mask  = in_mask & ~resolve_mask;

endmodule

// File: rtl/agu_resp_queue.sv
// AGU -> LSU decoupling queue with per-entry branch kill/resolve tracking.
// Optional AGU_RESPQ_BYPASS_EN: 0-cycle enq->deq path when the queue is empty.
module agu_resp_queue
  import agu_respq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_D,
  parameter int BR_W   = BR_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ROB_W  = ROB_W_D,
  parameter int LSQ_W  = LSQ_W_D
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [ADDR_W-1:0]          enq_addr,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       enq_mxcpt,
  input  logic                       enq_is_load,
  input  logic                       enq_is_sta,
  input  logic                       enq_is_std,
  input  logic [1:0]                 enq_mem_size,
  input  logic [ROB_W-1:0]           enq_rob_idx,
  input  logic [LSQ_W-1:0]           enq_ldq_idx,
  input  logic [LSQ_W-1:0]           enq_stq_idx,
  input  logic [BR_W-1:0]            enq_br_mask,
  input  logic [BR_W-1:0]            brupdate_resolve_mask,
  input  logic [BR_W-1:0]            brupdate_mispredict_mask,
  input  logic                       flush,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [ADDR_W-1:0]          deq_addr,
  output logic [DATA_W-1:0]          deq_data,
  output logic                       deq_mxcpt,
  output logic                       deq_is_load,
  output logic                       deq_is_sta,
  output logic                       deq_is_std,
  output logic [1:0]                 deq_mem_size,
  output logic [ROB_W-1:0]           deq_rob_idx,
  output logic [LSQ_W-1:0]           deq_ldq_idx,
  output logic [LSQ_W-1:0]           deq_stq_idx,
  output logic [BR_W-1:0]            deq_br_mask,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [DEPTH-1:0] valid_q, valid_n;
  logic [BR_W-1:0] mask_q [DEPTH];
  logic [BR_W-1:0] mask_n [DEPTH];
  payload_t        pl_q [DEPTH];

  payload_t        enq_pl;
  logic            enq_v_n;
  logic [BR_W-1:0] enq_m_n;
  entry_t          enq_ent, head_ent, deq_ent;
  logic            empty, enq_fire, wr, pop, head_v;

  for (genvar i = 0; i < DEPTH; i++) begin : g_upd
    agu_respq_brmask_upd #(.BR_W(BR_W)) u_upd (
      .in_valid        (valid_q[i]),
      .in_mask         (mask_q[i]),
      .resolve_mask    (brupdate_resolve_mask),
      .mispredict_mask (brupdate_mispredict_mask),
      .out_valid       (valid_n[i]),
      .out_mask        (mask_n[i])
    );
  end

  agu_respq_brmask_upd #(.BR_W(BR_W)) u_enq_upd (
    .in_valid        (1'b1),
    .in_mask         (enq_br_mask),
    .resolve_mask    (brupdate_resolve_mask),
    .mispredict_mask (brupdate_mispredict_mask),
    .out_valid       (enq_v_n),
    .out_mask        (enq_m_n)
  );

  always_comb begin
    enq_pl          = '0;
    enq_pl.addr     = enq_addr;
    enq_pl.data     = enq_data;
    enq_pl.mxcpt    = enq_mxcpt;
    enq_pl.is_load  = enq_is_load;
    enq_pl.is_sta   = enq_is_sta;
    enq_pl.is_std   = enq_is_std;
    enq_pl.mem_size = enq_mem_size;
    enq_pl.rob_idx  = enq_rob_idx;
    enq_pl.ldq_idx  = enq_ldq_idx;
    enq_pl.stq_idx  = enq_stq_idx;
  end

  assign enq_ent  = {enq_v_n, enq_m_n, enq_pl};
  assign head_ent = {valid_n[head_q], mask_n[head_q], pl_q[head_q]};

  assign empty     = (count_q == '0);
  assign enq_ready = (count_q != FULL);
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign head_v    = head_ent.valid & ~flush;

`ifdef AGU_RESPQ_BYPASS_EN
  logic byp;
  assign byp       = empty & ~flush;
  assign deq_ent   = byp ? enq_ent : head_ent;
  assign deq_valid = byp ? (enq_valid & enq_ent.valid) : head_v;
  assign wr        = enq_fire & ~(byp & deq_valid & deq_ready);
`else
  assign deq_ent   = head_ent;
  assign deq_valid = head_v;
  assign wr        = enq_fire;
`endif

  // Killed entries linger as bubbles; drop one per cycle when at the head.
  assign pop = ~empty & (~valid_q[head_q] | (head_v & deq_ready));

  assign deq_addr     = deq_ent.pl.addr;
  assign deq_data     = deq_ent.pl.data;
  assign deq_mxcpt    = deq_ent.pl.mxcpt;
  assign deq_is_load  = deq_ent.pl.is_load;
  assign deq_is_sta   = deq_ent.pl.is_sta;
  assign deq_is_std   = deq_ent.pl.is_std;
  assign deq_mem_size = deq_ent.pl.mem_size;
  assign deq_rob_idx  = deq_ent.pl.rob_idx;
  assign deq_ldq_idx  = deq_ent.pl.ldq_idx;
  assign deq_stq_idx  = deq_ent.pl.stq_idx;
  assign deq_br_mask  = deq_ent.br_mask;
  assign count        = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_n;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (wr) begin
        valid_q[tail_q] <= enq_ent.valid;
        tail_q          <= tail_q + 1'b1;
      end
      unique case ({wr, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload and masks carry no reset; valid_q qualifies them.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      mask_q[i] <= mask_n[i];
    end
    if (wr) begin
      pl_q[tail_q]   <= enq_ent.pl;
      mask_q[tail_q] <= enq_ent.br_mask;
    end
  end

`ifndef SYNTHESIS
  a_no_overrun: assert property (@(posedge clock) disable iff (reset)
    !(enq_valid && !enq_ready));
  a_ld_sta_excl: assert property (@(posedge clock) disable iff (reset)
    !(enq_valid && enq_is_sta && enq_is_load));
  a_count_max: assert property (@(posedge clock) disable iff (reset)
    count_q <= FULL);
`endif

endmodule

// File: doc/agu_resp_queue.md
Name: agu_resp_queue

Overview:
- Decoupling buffer directly downstream of the memory address-calculation unit; accepts its per-cycle response (address, store data, misalignment flag, uop tags) and presents it to the load/store unit with a ready/valid handshake.
- Tracks branch speculation per entry: kills entries on mispredict and clears resolved bits every cycle, so the LSU never sees a killed uop.
- Absorbs LSU back-pressure (TLB miss, dcache nack) without stalling issue.

Parameters:
DEPTH, 4, number of entries (power of two, >=2)
BR_W, 20, branch mask width
ADDR_W, 40, virtual address width
DATA_W, 65, store data width
ROB_W, 7, ROB index width
LSQ_W, 5, LDQ/STQ index width

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-high reset
enq_valid  in  1  AGU response valid
enq_ready  out  1  queue can accept this cycle
enq_addr  in  ADDR_W  computed address
enq_data  in  DATA_W  store data
enq_mxcpt  in  1  misaligned exception flag
enq_is_load  in  1  uop is load
enq_is_sta  in  1  uop is store-address
enq_is_std  in  1  uop is store-data
enq_mem_size  in  2  access size (0=B,1=H,2=W,3=D)
enq_rob_idx  in  ROB_W  ROB index
enq_ldq_idx  in  LSQ_W  LDQ index
enq_stq_idx  in  LSQ_W  STQ index
enq_br_mask  in  BR_W  branch mask
brupdate_resolve_mask  in  BR_W  resolved branches this cycle
brupdate_mispredict_mask  in  BR_W  mispredicted branches this cycle
flush  in  1  pipeline flush (exception/rollback)
deq_valid  out  1  head entry valid for LSU
deq_ready  in  1  LSU accepts head
deq_addr, deq_data, deq_mxcpt, deq_is_load, deq_is_sta, deq_is_std, deq_mem_size, deq_rob_idx, deq_ldq_idx, deq_stq_idx  out  as enq_*  head payload
deq_br_mask  out  BR_W  head mask with current resolve bits cleared
count  out  $clog2(DEPTH)+1  occupied slots, killed bubbles included

Behaviour:
- Storage: circular buffer with head/tail pointers of width $clog2(DEPTH) that wrap naturally. Per-entry valid bit. Registered count.
- Reset (async) and flush (sync, effective next cycle): head=tail=0, count=0, all valid=0. deq_valid=0, enq_ready=1 after reset. Payload registers are not reset.
- enq_ready = (count != DEPTH). It does not depend on deq_ready (no comb path).
- Enqueue fire = enq_valid & enq_ready & ~flush.
  - Writes slot[tail], advances tail, increments count.
  - Stored valid = ~|(enq_br_mask & mispredict). Stored mask = enq_br_mask & ~resolve.
- Every cycle, for every valid entry:
  - valid cleared if |(br_mask & mispredict).
  - br_mask &= ~resolve.
  - The enqueued entry gets the same treatment in its write cycle.
- deq_valid = valid[head] & ~|(br_mask[head] & mispredict) & ~flush.
- Dequeue fire = deq_valid & deq_ready: advances head, decrements count.
- Bubble skip: if count!=0 and valid[head]==0, head advances and count decrements with no deq_valid. At most one pop per cycle.
- Simultaneous enqueue and pop: count unchanged.
- Latency: enqueue to earliest deq_valid is 1 cycle.
- Full: enq_ready=0 even if deq_ready=1 that cycle. Killed bubbles still occupy slots until skipped.
- Payload is held stable while deq_valid & ~deq_ready, except br_mask, which only loses bits.
- Non-synthesis assertions:
  - enq_valid & ~enq_ready never occurs.
  - enq_is_sta & enq_is_load never both set.
  - count <= DEPTH.

Optional Feature:
AGU_RESPQ_BYPASS_EN
- Defined: when count==0 and not flushing, deq_* is driven combinationally from enq_* (br_mask with resolve cleared, killed per mispredict), giving 0-cycle latency. If deq_ready=1 the entry is not written. Otherwise it is written normally.
- Undefined: strict 1-cycle registered path; no enq-to-deq combinational path.

Decomposition:
- Package agu_respq_pkg: entry struct typedef (payload + br_mask + valid), mem_size constants, default parameter constants.
- One sub-module, agu_respq_brmask_upd: a combinational per-entry kill/resolve update, instantiated DEPTH+1 times (entries plus the enqueue path).

Test Plan:
- Reset, then enqueue addr=0x80001000, rob=5, one cycle with deq_ready=1 -> next cycle deq_valid=1, deq_addr=0x80001000, deq_rob_idx=5, count 1->0.
- deq_ready=0, enqueue 4 entries -> count=4, enq_ready=0. Release deq_ready -> 4 dequeues in order. Tail wraps to 0, enq_ready=1 after the first dequeue.
- Enqueue entries with br_mask 0x1, 0x2, 0x1. Pulse mispredict=0x1 -> entries 0 and 2 killed, bubbles skipped, only the 0x2 entry dequeued. Resolve=0x2 -> deq_br_mask=0.
- Enqueue with br_mask=0x4 in the same cycle as mispredict=0x4 -> slot consumed, never presented. count returns to 0 after the skip.
- Flush with 3 entries and a simultaneous enqueue -> next cycle count=0, deq_valid=0, nothing dequeued.
- With AGU_RESPQ_BYPASS_EN: queue empty, deq_ready=1, enqueue addr=0x40 -> deq_valid=1 and deq_addr=0x40 in the same cycle, count stays 0.
